// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame master and the echo slave it drives.
package spi_frame_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_SEND,
    ST_WAIT_START,
    ST_RECV,
    ST_STOP,
    ST_DONE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_frame_master_shift8.sv
// Loadable MSB-out shift register with serial input at the LSB; load wins over shift.
module spi_shift8
  import spi_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 msb
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)        data <= '0;
    else if (load)     data <= load_data;
    else if (shift_en) data <= {data[DATA_BITS-2:0], serial_in};
  end

  assign msb = data[DATA_BITS-1];

endmodule

// File: rtl/spi_frame_master.sv
// SPI frame master: sends a byte as select/start/MOSI frame, then captures the
// framed MISO reply with start-bit timeout and stop-bit error reporting.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 cs_n,
  output logic                 start_n,
  output logic                 mosi,
  input  logic                 miso,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err_frame,
  output logic                 rx_err_timeout,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  state_t               state, state_next;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 accept, timeout_hit, tx_msb;
  logic [DATA_BITS-1:0] unused_tx_bits;
  logic                 unused_rx_msb;

  assign accept      = (state == ST_IDLE) && tx_valid;
  assign timeout_hit = (state == ST_WAIT_START) && (miso != START_LEVEL) && (tmo_cnt == T_LAST);

  spi_shift8 u_tx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (tx_data),
    .shift_en  (state == ST_SEND),
    .serial_in (1'b0),
    .data      (unused_tx_bits),
    .msb       (tx_msb)
  );

  // A missing reply reports 0x00, so the RX register is cleared on timeout.
  spi_shift8 u_rx_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timeout_hit),
    .load_data ('0),
    .shift_en  (state == ST_RECV),
    .serial_in (miso),
    .data      (rx_data),
    .msb       (unused_rx_msb)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    tx_ready   = 1'b0;
    busy       = 1'b1;
    cs_n       = 1'b0;
    start_n    = 1'b1;
    mosi       = 1'b0;
    rx_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        cs_n     = 1'b1;
        if (tx_valid) state_next = ST_SELECT;
      end
      ST_SELECT: state_next = ST_START;
      ST_START: begin
        start_n    = 1'b0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        mosi = tx_msb;
        if (bit_cnt == B_LAST) state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (miso == START_LEVEL)  state_next = ST_RECV;
        else if (tmo_cnt == T_LAST) state_next = ST_DONE;
      end
      ST_RECV: if (bit_cnt == B_LAST) state_next = ST_STOP;
      ST_STOP: state_next = ST_DONE;
      ST_DONE: begin
        cs_n       = 1'b1;
        rx_valid   = 1'b1;
        state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        cs_n = 1'b1;
        if (gap_cnt == G_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The bit counter wraps to zero exactly at the end of SEND and RECV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      rx_err_frame   <= 1'b0;
      rx_err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_SEND || state == ST_RECV) bit_cnt <= bit_cnt + 1'b1;
      tmo_cnt <= (state == ST_WAIT_START) ? tmo_cnt + 1'b1 : '0;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        rx_err_frame   <= 1'b0;
        rx_err_timeout <= 1'b0;
      end else begin
        if (state == ST_STOP && miso != STOP_LEVEL) rx_err_frame <= 1'b1;
        if (timeout_hit) rx_err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: an echo-slave model answers each frame and a
// cycle-accurate expectation is computed from the frame timing rules.
module tb_spi_frame_master;

  localparam int TIMEOUT_CYCLES = 32;
  localparam int GAP_CYCLES     = 2;

  typedef struct packed {
    int         rel;
    logic [7:0] data;
    logic       frame;
    logic       tout;
  } result_t;

  logic       clk, rst_n, tx_valid, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_ready, cs_n, start_n, mosi, rx_valid, rx_err_frame, rx_err_timeout, busy;

  int pass_cnt, total_cnt;
  int cyc;
  int accept_cyc[$];
  result_t results[$];
  logic cs_log[16][64];
  logic start_log[16][64];
  logic ready_log[16][64];
  logic mosi_log[16][64];

  int         slave_k;
  bit         slave_mute, slave_override_en;
  logic [7:0] slave_override;
  logic       slave_stop;

  spi_frame_master #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .cs_n           (cs_n),
    .start_n        (start_n),
    .mosi           (mosi),
    .miso           (miso),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_err_frame   (rx_err_frame),
    .rx_err_timeout (rx_err_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) accept_cyc.push_back(cyc);
    cyc++;
  end

  // Logs outputs per frame, indexed by cycle number relative to that frame's accept edge.
  always @(negedge clk) begin : monitor
    int fi;
    int rel;
    if (accept_cyc.size() > 0) begin
      fi  = accept_cyc.size() - 1;
      rel = cyc - accept_cyc[fi];
      if (fi < 16 && rel < 64) begin
        cs_log[fi][rel]    = cs_n;
        start_log[fi][rel] = start_n;
        ready_log[fi][rel] = tx_ready;
        mosi_log[fi][rel]  = mosi;
      end
      if (rx_valid) results.push_back('{rel, rx_data, rx_err_frame, rx_err_timeout});
    end
  end

  // Echo slave: collects the 8 MOSI bits after start_n, idles k cycles, then replies framed.
  always begin : echo_slave
    logic [7:0] got;
    logic [7:0] reply;
    bit         aborted;
    @(negedge clk);
    miso = 1'b1;
    if (rst_n && !cs_n && !start_n) begin
      aborted = 1'b0;
      got     = 8'h00;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (cs_n) aborted = 1'b1;
        got = {got[6:0], mosi};
      end
      if (!aborted && !slave_mute) begin
        reply = slave_override_en ? slave_override : got;
        repeat (slave_k) @(negedge clk);
        @(negedge clk);
        miso = 1'b0;
        for (int i = 7; i >= 0; i--) begin
          @(negedge clk);
          miso = reply[i];
        end
        @(negedge clk);
        miso = slave_stop;
      end
    end
  end

  function automatic result_t model_frame(input logic [7:0] sent, input int k, input bit mute,
                                          input bit ovr_en, input logic [7:0] ovr, input logic stop);
    result_t r;
    if (mute) begin
      r.rel = 11 + TIMEOUT_CYCLES; r.data = 8'h00; r.frame = 1'b0; r.tout = 1'b1;
    end else begin
      r.rel = 21 + k; r.data = ovr_en ? ovr : sent; r.frame = (stop == 1'b0); r.tout = 1'b0;
    end
    return r;
  endfunction

  task automatic set_slave(input int k, input bit mute, input bit ovr_en, input logic [7:0] ovr,
                           input logic stop);
    slave_k = k; slave_mute = mute; slave_override_en = ovr_en; slave_override = ovr; slave_stop = stop;
  endtask

  // Returns at the negedge of cycle 1 of the frame.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      total_cnt++;
      $display("FAIL send_ready: tx_ready stayed low for %0d cycles", n);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input string name, output result_t got);
    int t;
    t = 0;
    while (results.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (results.size() < n) begin
      total_cnt++;
      $display("FAIL %s: no rx_valid within 200 cycles", name);
      got = '{-1, 8'h00, 1'b0, 1'b0};
    end else begin
      got = results.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({cs_n, start_n, mosi, tx_ready, busy, rx_valid, rx_err_frame, rx_err_timeout} !== 8'b1101_0000)
      $display("FAIL reset_ctrl: got %b required 11010000",
               {cs_n, start_n, mosi, tx_ready, busy, rx_valid, rx_err_frame, rx_err_timeout});
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", rx_data);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, tx_ready, cs_n} !== 3'b011) $display("FAIL idle_after_reset: got %b required 011", {busy, tx_ready, cs_n});
    else pass_cnt++;
  endtask

  task automatic test_loopback();
    result_t got, exp;
    logic [7:0] obs;
    int fi, k;
    k = $urandom_range(0, 5);
    set_slave(k, 1'b0, 1'b0, 8'h00, 1'b1);
    send_byte(8'hA9);
    fi = accept_cyc.size() - 1;
    wait_results(1, "loopback", got);
    exp = model_frame(8'hA9, k, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int c = 3; c <= 10; c++) obs[10 - c] = mosi_log[fi][c];
    total_cnt++;
    if (obs !== 8'hA9) $display("FAIL loopback_mosi: got %h required a9", obs);
    else pass_cnt++;
    total_cnt++;
    if ({cs_log[fi][1], start_log[fi][1], start_log[fi][2], start_log[fi][3]} !== 4'b0101)
      $display("FAIL loopback_select_start: got %b required 0101",
               {cs_log[fi][1], start_log[fi][1], start_log[fi][2], start_log[fi][3]});
    else pass_cnt++;
    total_cnt++;
    if (got !== exp) $display("FAIL loopback_result: got rel=%0d data=%h fe=%b to=%b required rel=%0d data=%h fe=%b to=%b",
                              got.rel, got.data, got.frame, got.tout, exp.rel, exp.data, exp.frame, exp.tout);
    else pass_cnt++;
  endtask

  task automatic test_random_loopback();
    result_t got, exp;
    logic [7:0] b;
    int k;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      k = (i == 3) ? TIMEOUT_CYCLES - 1 : $urandom_range(0, TIMEOUT_CYCLES - 1);
      set_slave(k, 1'b0, 1'b0, 8'h00, 1'b1);
      send_byte(b);
      wait_results(1, "random_loopback", got);
      exp = model_frame(b, k, 1'b0, 1'b0, 8'h00, 1'b1);
      total_cnt++;
      if (got !== exp) $display("FAIL random_loopback_%0d: got rel=%0d data=%h fe=%b to=%b required rel=%0d data=%h",
                                i, got.rel, got.data, got.frame, got.tout, exp.rel, exp.data);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    result_t got, exp;
    int fi;
    set_slave(0, 1'b1, 1'b0, 8'h00, 1'b1);
    send_byte(8'h5A);
    fi = accept_cyc.size() - 1;
    wait_results(1, "timeout", got);
    exp = model_frame(8'h5A, 0, 1'b1, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (got !== exp) $display("FAIL timeout_result: got rel=%0d data=%h fe=%b to=%b required rel=%0d data=%h fe=%b to=%b",
                              got.rel, got.data, got.frame, got.tout, exp.rel, exp.data, exp.frame, exp.tout);
    else pass_cnt++;
    total_cnt++;
    if ({cs_log[fi][42], cs_log[fi][43]} !== 2'b01)
      $display("FAIL timeout_cs_n: got %b at cycles 42,43 required 01", {cs_log[fi][42], cs_log[fi][43]});
    else pass_cnt++;
  endtask

  task automatic test_frame_error();
    result_t got, exp;
    int k;
    k = $urandom_range(0, 10);
    set_slave(k, 1'b0, 1'b1, 8'h3C, 1'b0);
    send_byte(8'hE7);
    wait_results(1, "frame_error", got);
    exp = model_frame(8'hE7, k, 1'b0, 1'b1, 8'h3C, 1'b0);
    total_cnt++;
    if (got !== exp) $display("FAIL frame_error_result: got rel=%0d data=%h fe=%b to=%b required rel=%0d data=%h fe=%b to=%b",
                              got.rel, got.data, got.frame, got.tout, exp.rel, exp.data, exp.frame, exp.tout);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({rx_err_frame, rx_data} !== {1'b1, 8'h3C})
      $display("FAIL frame_error_hold: got fe=%b data=%h required fe=1 data=3c", rx_err_frame, rx_data);
    else pass_cnt++;
    set_slave(2, 1'b0, 1'b0, 8'h00, 1'b1);
    send_byte(8'h96);
    total_cnt++;
    if (rx_err_frame !== 1'b0) $display("FAIL frame_error_clear: got %b required 0", rx_err_frame);
    else pass_cnt++;
    wait_results(1, "frame_error_next", got);
    exp = model_frame(8'h96, 2, 1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (got !== exp) $display("FAIL frame_error_next: got rel=%0d data=%h fe=%b required rel=%0d data=%h fe=%b",
                              got.rel, got.data, got.frame, exp.rel, exp.data, exp.frame);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    result_t got, exp;
    set_slave(0, 1'b0, 1'b0, 8'h00, 1'b1);
    send_byte(8'hC3);
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({cs_n, busy} !== 2'b01) $display("FAIL mid_frame_active: got cs_n,busy=%b required 01", {cs_n, busy});
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({cs_n, tx_ready, busy} !== 3'b110)
      $display("FAIL mid_frame_reset: got cs_n,tx_ready,busy=%b required 110", {cs_n, tx_ready, busy});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total_cnt++;
    if (results.size() != 0) $display("FAIL mid_frame_no_valid: got %0d results required 0", results.size());
    else pass_cnt++;
    send_byte(8'h55);
    wait_results(1, "after_reset", got);
    exp = model_frame(8'h55, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (got !== exp) $display("FAIL after_reset_result: got rel=%0d data=%h fe=%b to=%b required rel=%0d data=%h",
                              got.rel, got.data, got.frame, got.tout, exp.rel, exp.data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    result_t got1, got2, exp1, exp2;
    int base, fi, n, highs, cs_high;
    set_slave(0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    while (!tx_ready) @(negedge clk);
    base     = accept_cyc.size();
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h80;
    n = 0;
    while (accept_cyc.size() < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    fi = base;
    total_cnt++;
    if (accept_cyc.size() < base + 2) $display("FAIL b2b_second_accept: none within 100 cycles");
    else if (accept_cyc[fi + 1] - accept_cyc[fi] != 24)
      $display("FAIL b2b_second_accept: got cycle %0d required 24", accept_cyc[fi + 1] - accept_cyc[fi]);
    else pass_cnt++;
    highs = 0;
    for (int c = 1; c <= 23; c++) highs += int'(ready_log[fi][c]);
    total_cnt++;
    if (highs != 0) $display("FAIL b2b_ready_low: got %0d high cycles in 1..23 required 0", highs);
    else pass_cnt++;
    cs_high = 0;
    for (int c = 21; c <= 24; c++) cs_high += int'(cs_log[fi][c]);
    total_cnt++;
    if ({cs_log[fi][20], 3'(cs_high)} !== 4'b0100)
      $display("FAIL b2b_cs_gap: got cs_n@20=%b high count 21..24=%0d required 0 and 4", cs_log[fi][20], cs_high);
    else pass_cnt++;
    wait_results(1, "b2b_first", got1);
    wait_results(1, "b2b_second", got2);
    exp1 = model_frame(8'h01, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    exp2 = model_frame(8'h80, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if ({got1, got2} !== {exp1, exp2})
      $display("FAIL b2b_results: got %h/%0d then %h/%0d required %h/%0d then %h/%0d",
               got1.data, got1.rel, got2.data, got2.rel, exp1.data, exp1.rel, exp2.data, exp2.rel);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    result_t got, exp;
    int base;
    set_slave(5, 1'b0, 1'b0, 8'h00, 1'b1);
    send_byte(8'h3A);
    base = accept_cyc.size();
    repeat (12) @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_results(1, "busy_ignore", got);
    exp = model_frame(8'h3A, 5, 1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (got !== exp) $display("FAIL busy_ignore_result: got rel=%0d data=%h required rel=%0d data=%h",
                              got.rel, got.data, exp.rel, exp.data);
    else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (accept_cyc.size() != base) $display("FAIL busy_ignore_accepts: got %0d extra accepts required 0",
                                            accept_cyc.size() - base);
    else pass_cnt++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pass_cnt = 0; total_cnt = 0; cyc = 0;
    set_slave(0, 1'b0, 1'b0, 8'h00, 1'b1);
    test_reset();
    test_loopback();
    test_random_loopback();
    test_timeout();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_busy_ignore();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Master-side framer that drives the SPI echo slave. It accepts a byte on a valid/ready handshake and serialises it as a select, start-bit and MSB-first MOSI frame. It then captures the slave's MISO reply (start bit 0, 8 data bits MSB-first, stop bit 1) and returns the byte with framing and timeout status. It sits directly upstream of the slave, driving its chip select, start and MOSI inputs and consuming its MISO output.

## Interface
- `TIMEOUT_CYCLES`, default 32: maximum number of WAIT_START samples before the reply is declared missing.
- `GAP_CYCLES`, default 2: number of cycles `cs_n` is held high between frames.
- `clk` input, 1: single clock; all state changes on rising edge.
- `rst_n` input, 1: reset is synchronous and active-low.
- `tx_data` input, 8: byte to send.
- `tx_valid` input, 1: `tx_data` is valid.
- `tx_ready` output, 1: high only in IDLE.
- `cs_n` output, 1: chip select to slave, active low.
- `start_n` output, 1: start strobe to slave, active low.
- `mosi` output, 1: serial data to slave.
- `miso` input, 1: serial reply from slave.
- `rx_data` output, 8: captured reply byte.
- `rx_valid` output, 1: one-cycle pulse when a result is ready.
- `rx_err_frame` output, 1: stop bit was sampled 0; qualified by `rx_valid`.
- `rx_err_timeout` output, 1: no start bit seen; qualified by `rx_valid`.
- `busy` output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, SELECT, START, SEND, WAIT_START, RECV, STOP, DONE, GAP. Outputs are a Moore decode of the registered state.
- **IDLE:** `cs_n`=1, `start_n`=1, `mosi`=0. On `tx_valid & tx_ready`, latch `tx_data` into the shift register and go to SELECT.
- **SELECT (1 cycle):** `cs_n`=0.
- **START (1 cycle):** `cs_n`=0, `start_n`=0.
- **SEND (8 cycles):** `cs_n`=0, `start_n`=1. `mosi` = bit 7 down to bit 0, one bit per cycle.
- **WAIT_START:**
  - `mosi`=0, `cs_n`=0. `miso` is sampled every edge.
  - A sample of 0 goes to RECV.
  - After `TIMEOUT_CYCLES` samples with none at 0, clear `rx_data` to 0x00, set `rx_err_timeout`, and go to DONE.
- **RECV (8 cycles):** shift `miso` in MSB-first.
- **STOP (1 cycle):** sample `miso`. A value of 0 sets `rx_err_frame`; `rx_data` still holds the received byte.
- **DONE (1 cycle):** `rx_valid`=1, `cs_n`=1.
- **GAP:** `cs_n`=1 for `GAP_CYCLES` cycles, then IDLE. If `GAP_CYCLES`=0, go from DONE straight to IDLE.
- **Error flags:** cleared on each new accept. They hold their value until the next accept.
- **Flow control:**
  - `tx_valid` outside IDLE is ignored. No buffering.
  - A byte held on `tx_valid` through a frame is accepted again at the next IDLE.
- **Reset:**
  - Reset values: `cs_n`=1, `start_n`=1, `mosi`=0, `tx_ready`=1, `busy`=0, `rx_data`=0x00, `rx_valid`=0, both error flags 0.
  - Reset asserted mid-frame returns to IDLE on the next edge, drives `cs_n` high, discards the byte, and issues no `rx_valid`.

## Timing
- Cycle 0 is the accept edge. SELECT is cycle 1, START is cycle 2, SEND is cycles 3–10, WAIT_START begins at cycle 11.
- With the start bit sampled at WAIT cycle k (k = 0..TIMEOUT_CYCLES−1):
  - RECV is cycles 12+k to 19+k.
  - STOP is cycle 20+k.
  - DONE (`rx_valid`) is cycle 21+k.
- Minimum latency from accept to `rx_valid` is 21 cycles.
- Timeout: with all samples high, `rx_valid` occurs at cycle 11+`TIMEOUT_CYCLES` (43 at default).
- Next accept is possible at DONE+1+`GAP_CYCLES`.
- Counters:
  - Bit counter is 3 bits, wrapping 7→0 only at the phase exit.
  - Timeout counter is sized `$clog2(TIMEOUT_CYCLES+1)`, with no wrap.

## Structure
- Package `spi_frame_pkg` holds:
  - the state enum;
  - `DATA_BITS`=8;
  - `START_LEVEL`=0;
  - `STOP_LEVEL`=1.
- The slave side of the codebase shares this package.
- One sub-module, `spi_shift8`: an 8-bit loadable shift register with MSB-out and serial-in-LSB, enable-gated. It is used once for TX and once for RX.

## Test plan
- **Loopback:** echo-slave model, `tx_data`=0xA9.
  - `mosi` is 1,0,1,0,1,0,0,1 over cycles 3–10.
  - `rx_data`=0xA9 with `rx_valid` at 21+k, no error flags.
- **Timeout:** `miso` held 1 with `TIMEOUT_CYCLES`=32.
  - `rx_valid` at cycle 43, `rx_err_timeout`=1, `rx_data`=0x00, `cs_n` high at cycle 43.
- **Frame error:** model replies 0x3C with stop bit 0.
  - `rx_data`=0x3C, `rx_err_frame`=1, `rx_err_timeout`=0.
- **Reset mid-frame:** `rst_n` low during SEND cycle 6.
  - `cs_n`=1 and `tx_ready`=1 on the next edge.
  - No `rx_valid`.
  - The next frame with 0x55 completes normally.
- **Back-to-back:** `tx_valid` held with 0x01 then 0x80, k=0, GAP_CYCLES=2.
  - `tx_ready` is low during cycles 1–23; the second accept is at cycle 24.
  - `cs_n` is high during cycles 21–24.
  - Both bytes are returned in order.
- **Busy ignore:** pulse `tx_valid` with 0xFF during WAIT_START.
  - No effect on the frame; `rx_data` equals the original byte.
